// File: rtl/pin_entry_ctrl.sv
// rtl/pin_entry_ctrl.sv - keypad PIN entry controller with synchronized key events and entry timeout
// Optional try counting and lockout are built when PIN_LOCKOUT_EN is defined.
module pin_entry_ctrl #(
    parameter int          DIGITS    = 4,
    parameter logic [27:0] TIMEOUT   = 28'd27000000,
    parameter int          MAX_TRIES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  key,
    input  logic        keypad_pressed,
    input  logic [15:0] code_in,
    output logic [15:0] entry,
    output logic [2:0]  digit_count,
    output logic        unlock,
    output logic        error,
    output logic        locked
);

`ifdef PIN_LOCKOUT_EN
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK, S_LOCKOUT} state_t;
    localparam int TW = $clog2(MAX_TRIES + 1);
    logic [TW-1:0] tries_q, tries_d;
    logic          locked_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_CHECK} state_t;
`endif

    localparam logic [15:0] CMP_MASK = 16'((32'd1 << (4 * DIGITS)) - 32'd1);
    localparam logic [2:0]  FULL     = 3'(DIGITS);
    localparam logic [27:0] T_LAST   = TIMEOUT - 28'd1;

    state_t      state_q;
    logic        sync1_q, sync2_q, prev_q, evt_q, armed_q;
    logic [1:0]  fill_q;
    logic [4:0]  key_q;
    logic [15:0] entry_q, entry_d;
    logic [2:0]  count_q;
    logic [27:0] timer_q, timer_d;
    logic        unlock_q, error_q;
    logic        is_digit, is_star, is_hash, valid_evt, match, timer_done;

    always_comb begin
        is_digit   = (key_q <= 5'd9);
        is_star    = (key_q == 5'd15);
        is_hash    = (key_q == 5'd14);
        valid_evt  = evt_q & (is_digit | is_star | is_hash);
        entry_d    = {entry_q[11:0], key_q[3:0]};
        timer_d    = timer_q + 28'd1;
        timer_done = (timer_q == T_LAST);
        match      = (count_q == FULL) && ((entry_q & CMP_MASK) == (code_in & CMP_MASK));
`ifdef PIN_LOCKOUT_EN
        tries_d    = tries_q + 1'b1;
`endif
    end

    // A key held through reset must not count: edges are only accepted once the
    // refilled synchronizer has shown the line low at least once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            fill_q   <= 2'b00;
            armed_q  <= 1'b0;
            evt_q    <= 1'b0;
            key_q    <= 5'd31;
            entry_q  <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            unlock_q <= 1'b0;
            error_q  <= 1'b0;
`ifdef PIN_LOCKOUT_EN
            tries_q  <= '0;
            locked_q <= 1'b0;
`endif
        end else begin
            sync1_q  <= keypad_pressed;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            fill_q   <= {fill_q[0], 1'b1};
            armed_q  <= armed_q | (fill_q[1] & ~sync2_q);
            evt_q    <= sync2_q & ~prev_q & armed_q;
            key_q    <= key;
            unlock_q <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_ENTRY: begin
                    if (valid_evt) begin
                        timer_q <= '0;
                        if (is_digit) begin
                            if (count_q < FULL) begin
                                entry_q <= entry_d;
                                count_q <= count_q + 3'd1;
                                state_q <= S_ENTRY;
                            end
                        end else if (is_star) begin
                            entry_q <= '0;
                            count_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            state_q <= S_CHECK;
                        end
                    end else if (state_q == S_ENTRY) begin
                        if (timer_done) begin
                            entry_q <= '0;
                            count_q <= '0;
                            timer_q <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            timer_q <= timer_d;
                        end
                    end
                end
                S_CHECK: begin
                    entry_q  <= '0;
                    count_q  <= '0;
                    timer_q  <= '0;
                    state_q  <= S_IDLE;
                    unlock_q <= match;
                    error_q  <= ~match;
`ifdef PIN_LOCKOUT_EN
                    if (match) begin
                        tries_q <= '0;
                    end else begin
                        tries_q <= tries_d;
                        if (tries_d == TW'(MAX_TRIES)) begin
                            state_q  <= S_LOCKOUT;
                            locked_q <= 1'b1;
                        end
                    end
`endif
                end
`ifdef PIN_LOCKOUT_EN
                S_LOCKOUT: begin
                    if (timer_done) begin
                        timer_q  <= '0;
                        tries_q  <= '0;
                        locked_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end else begin
                        timer_q <= timer_d;
                    end
                end
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign entry       = entry_q;
    assign digit_count = count_q;
    assign unlock      = unlock_q;
    assign error       = error_q;
`ifdef PIN_LOCKOUT_EN
    assign locked      = locked_q;
`else
    assign locked      = 1'b0;
`endif

endmodule

// File: tb/tb_pin_entry_ctrl.sv
// tb/tb_pin_entry_ctrl.sv - self-checking bench for pin_entry_ctrl against a digit-queue reference model
module tb_pin_entry_ctrl;
    localparam logic [15:0] CODE = 16'h1234;
`ifdef PIN_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  key = 5'd31;
    logic        kp = 1'b0;
    logic [15:0] code_in = CODE;
    logic [15:0] entry;
    logic [2:0]  digit_count;
    logic        unlock, error, locked;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pin_entry_ctrl #(.DIGITS(4), .TIMEOUT(28'd100), .MAX_TRIES(3)) dut (
        .clk(clk), .rst(rst), .key(key), .keypad_pressed(kp), .code_in(code_in),
        .entry(entry), .digit_count(digit_count), .unlock(unlock), .error(error), .locked(locked)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   both_cnt = 0, long_cnt = 0, err_pulses = 0, lock_run = 0, last_lock_len = 0;
    logic prev_unl = 1'b0, prev_err = 1'b0;
    always @(negedge clk) begin
        prev_unl <= unlock;
        prev_err <= error;
        if (unlock && error) both_cnt <= both_cnt + 1;
        if ((unlock && prev_unl) || (error && prev_err)) long_cnt <= long_cnt + 1;
        if (error && !prev_err) err_pulses <= err_pulses + 1;
        if (locked) lock_run <= lock_run + 1;
        else if (lock_run != 0) begin
            last_lock_len <= lock_run;
            lock_run <= 0;
        end
    end

    // Reference model: the entered digits as a queue, plus a tries count.
    int m_digs[$];
    int m_tries = 0;
    bit m_lock = 1'b0;

    function automatic logic [15:0] m_entry();
        logic [15:0] e;
        e = '0;
        foreach (m_digs[i]) e = (e << 4) | 16'(m_digs[i]);
        return e;
    endfunction

    logic [15:0] s_entry2, s_entry3, s_entry4, x_e3, x_e4;
    logic [2:0]  s_cnt2, s_cnt3, s_cnt4, x_n3, x_n4;
    logic        s_unl4, s_err4, s_lock4, s_unl5, s_err5, x_unl, x_err, x_lock;
    int          s_cyc3;

    task automatic press_key(input logic [4:0] k, input int hold);
        @(negedge clk); key = k; kp = 1'b1;
        repeat (3) @(posedge clk);
        #1; s_entry2 = entry; s_cnt2 = digit_count;
        @(posedge clk); #1; s_entry3 = entry; s_cnt3 = digit_count; s_cyc3 = cyc;
        @(posedge clk); #1; s_entry4 = entry; s_cnt4 = digit_count;
        s_unl4 = unlock; s_err4 = error; s_lock4 = locked;
        @(posedge clk); #1; s_unl5 = unlock; s_err5 = error;
        repeat ((hold > 3) ? hold - 3 : 0) @(posedge clk);
        @(negedge clk); kp = 1'b0; key = 5'd31;
        repeat (4) @(negedge clk);
    endtask

    task automatic step(input logic [4:0] k, input int hold);
        logic [15:0] pe;
        logic [2:0]  pn;
        bit          ok;
        pe = m_entry();
        pn = 3'(m_digs.size());
        x_unl = 1'b0;
        x_err = 1'b0;
        if (!m_lock) begin
            if (k <= 5'd9) begin
                if (m_digs.size() < 4) m_digs.push_back(int'(k));
            end else if (k == 5'd15) begin
                m_digs.delete();
            end else if (k == 5'd14) begin
                ok = (pn == 3'd4) && (pe == CODE);
                x_unl = ok;
                x_err = !ok;
                m_digs.delete();
                m_tries = ok ? 0 : m_tries + 1;
                if (LOCK_EN && m_tries == 3) m_lock = 1'b1;
            end
        end
        x_e4 = m_entry();
        x_n4 = 3'(m_digs.size());
        x_e3 = (k == 5'd14) ? pe : x_e4;
        x_n3 = (k == 5'd14) ? pn : x_n4;
        x_lock = m_lock;
        press_key(k, hold);
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1; kp = 1'b0; key = 5'd31;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_digs.delete(); m_tries = 0; m_lock = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_unlock_end();
        for (int i = 0; i < 300 && locked !== 1'b0; i++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL lockout_end: locked=%b required 0 within 300 cycles", locked);
        end
        m_lock = 1'b0;
        m_tries = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (entry !== 16'h0)       begin errors++; $display("FAIL rst_entry: got %h required 0000", entry); end
        checks++; if (digit_count !== 3'd0)  begin errors++; $display("FAIL rst_count: got %0d required 0", digit_count); end
        checks++; if (unlock !== 1'b0)       begin errors++; $display("FAIL rst_unlock: got %b required 0", unlock); end
        checks++; if (error !== 1'b0)        begin errors++; $display("FAIL rst_error: got %b required 0", error); end
        checks++; if (locked !== 1'b0)       begin errors++; $display("FAIL rst_locked: got %b required 0", locked); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_unlock();
        logic [4:0] seq [4];
        seq = '{5'd1, 5'd2, 5'd3, 5'd4};
        do_reset();
        step(seq[0], 3);
        checks++; if (s_entry2 !== 16'h0 || s_cnt2 !== 3'd0) begin
            errors++; $display("FAIL latency_n2: got %h/%0d required 0000/0", s_entry2, s_cnt2); end
        checks++; if (s_entry3 !== x_e3 || s_cnt3 !== x_n3) begin
            errors++; $display("FAIL latency_n3: got %h/%0d required %h/%0d", s_entry3, s_cnt3, x_e3, x_n3); end
        for (int i = 1; i < 4; i++) step(seq[i], 3);
        checks++; if (s_entry3 !== 16'h1234 || s_cnt3 !== 3'd4) begin
            errors++; $display("FAIL four_digits: got %h/%0d required 1234/4", s_entry3, s_cnt3); end
        step(5'd14, 3);
        checks++; if (s_entry3 !== 16'h1234) begin errors++; $display("FAIL check_frozen: got %h required 1234", s_entry3); end
        checks++; if (s_unl4 !== 1'b1 || s_err4 !== 1'b0) begin
            errors++; $display("FAIL unlock_pulse: got unlock=%b error=%b required 1/0", s_unl4, s_err4); end
        checks++; if (s_entry4 !== 16'h0 || s_cnt4 !== 3'd0) begin
            errors++; $display("FAIL unlock_clear: got %h/%0d required 0000/0", s_entry4, s_cnt4); end
        checks++; if (s_unl5 !== 1'b0) begin errors++; $display("FAIL unlock_width: got %b required 0", s_unl5); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int d = 1; d <= 5; d++) step(5'(d), 3);
        checks++; if (s_entry3 !== 16'h1234 || s_cnt3 !== 3'd4) begin
            errors++; $display("FAIL fifth_digit: got %h/%0d required 1234/4", s_entry3, s_cnt3); end
        step(5'd15, 3);
        checks++; if (s_entry3 !== 16'h0 || s_cnt3 !== 3'd0) begin
            errors++; $display("FAIL star_clear: got %h/%0d required 0000/0", s_entry3, s_cnt3); end
        checks++; if (s_unl4 !== 1'b0 || s_err4 !== 1'b0 || s_unl5 !== 1'b0 || s_err5 !== 1'b0) begin
            errors++; $display("FAIL star_pulse: got %b%b%b%b required 0000", s_unl4, s_err4, s_unl5, s_err5); end
    endtask

    task automatic test_lockout();
        do_reset();
        step(5'd1, 3); step(5'd2, 3); step(5'd14, 3);
        checks++; if (s_err4 !== 1'b1 || s_unl4 !== 1'b0) begin
            errors++; $display("FAIL short_error: got error=%b unlock=%b required 1/0", s_err4, s_unl4); end
        for (int i = 0; i < 4; i++) step(5'd9, 3);
        step(5'd14, 3);
        checks++; if (s_err4 !== x_err) begin errors++; $display("FAIL wrong_error: got %b required %b", s_err4, x_err); end
        step(5'd14, 3);
        checks++; if (s_lock4 !== x_lock) begin errors++; $display("FAIL lock_enter: got %b required %b", s_lock4, x_lock); end
        step(5'd1, 3);
        checks++; if (s_entry3 !== x_e3 || s_cnt3 !== x_n3) begin
            errors++; $display("FAIL lock_ignore: got %h/%0d required %h/%0d", s_entry3, s_cnt3, x_e3, x_n3); end
        wait_unlock_end();
        repeat (2) @(negedge clk);
        checks++; if (last_lock_len !== (LOCK_EN ? 100 : 0)) begin
            errors++; $display("FAIL lock_length: got %0d required %0d", last_lock_len, LOCK_EN ? 100 : 0); end
        step(5'd15, 3);
        step(5'd5, 3);
        checks++; if (s_entry3 !== 16'h0005 || s_cnt3 !== 3'd1) begin
            errors++; $display("FAIL after_lock: got %h/%0d required 0005/1", s_entry3, s_cnt3); end
    endtask

    task automatic test_timeout();
        int c0, e0;
        do_reset();
        e0 = err_pulses;
        step(5'd7, 3);
        c0 = s_cyc3;
        while (cyc < c0 + 99) begin @(posedge clk); #1; end
        checks++; if (entry !== 16'h0007) begin errors++; $display("FAIL timeout_early: got %h required 0007", entry); end
        @(posedge clk); #1;
        checks++; if (entry !== 16'h0 || digit_count !== 3'd0) begin
            errors++; $display("FAIL timeout_clear: got %h/%0d required 0000/0", entry, digit_count); end
        repeat (2) @(negedge clk);
        checks++; if (err_pulses !== e0) begin errors++; $display("FAIL timeout_noerr: got %0d required %0d", err_pulses, e0); end
        m_digs.delete();
        step(5'd7, 3);
        c0 = s_cyc3;
        while (cyc < c0 + 95) begin @(posedge clk); #1; end
        @(negedge clk); key = 5'd8; kp = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (entry !== 16'h0078 || digit_count !== 3'd2) begin
            errors++; $display("FAIL timeout_restart: got %h/%0d required 0078/2", entry, digit_count); end
        @(negedge clk); kp = 1'b0; key = 5'd31;
    endtask

    task automatic test_held_and_reset();
        do_reset();
        step(5'd5, 50);
        checks++; if (entry !== 16'h0005 || digit_count !== 3'd1) begin
            errors++; $display("FAIL held_key: got %h/%0d required 0005/1", entry, digit_count); end
        step(5'd3, 3);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        checks++; if ({entry, digit_count, unlock, error, locked} !== 22'h0) begin
            errors++; $display("FAIL async_reset: got %h/%0d/%b%b%b required all 0", entry, digit_count, unlock, error, locked); end
        key = 5'd6; kp = 1'b1;
        @(negedge clk); rst = 1'b0;
        m_digs.delete(); m_tries = 0; m_lock = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (digit_count !== 3'd0) begin errors++; $display("FAIL held_thru_reset: got %0d required 0", digit_count); end
        kp = 1'b0; key = 5'd31;
        repeat (4) @(negedge clk);
        step(5'd6, 3);
        checks++; if (s_entry3 !== 16'h0006 || s_cnt3 !== 3'd1) begin
            errors++; $display("FAIL fresh_edge: got %h/%0d required 0006/1", s_entry3, s_cnt3); end
    endtask

    task automatic test_random();
        logic [4:0] ign [5];
        logic [4:0] k;
        bit         last_ign;
        int         r;
        ign = '{5'd10, 5'd11, 5'd12, 5'd13, 5'd31};
        last_ign = 1'b0;
        do_reset();
        for (int it = 0; it < 50; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                for (int d = 1; d <= 4; d++) step(5'(d), 3);
                k = 5'd14;
            end else if (r < 60 || (r < 70 && last_ign)) k = 5'($urandom_range(0, 9));
            else if (r < 70) k = ign[$urandom_range(0, 4)];
            else if (r < 80) k = 5'd15;
            else k = 5'd14;
            last_ign = (k >= 5'd10 && k <= 5'd13) || k == 5'd31;
            step(k, $urandom_range(3, 8));
            checks++; if (s_entry3 !== x_e3 || s_cnt3 !== x_n3) begin
                errors++; $display("FAIL rnd_entry: key %0d got %h/%0d required %h/%0d", k, s_entry3, s_cnt3, x_e3, x_n3); end
            checks++; if (s_unl4 !== x_unl || s_err4 !== x_err) begin
                errors++; $display("FAIL rnd_pulse: key %0d got %b/%b required %b/%b", k, s_unl4, s_err4, x_unl, x_err); end
            checks++; if (s_entry4 !== x_e4 || s_cnt4 !== x_n4 || s_lock4 !== x_lock) begin
                errors++; $display("FAIL rnd_after: key %0d got %h/%0d/%b required %h/%0d/%b", k, s_entry4, s_cnt4, s_lock4, x_e4, x_n4, x_lock); end
            if (m_lock) wait_unlock_end();
        end
    endtask

    task automatic test_pulse_rules();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL pulse_overlap: got %0d required 0", both_cnt); end
        checks++; if (long_cnt !== 0) begin errors++; $display("FAIL pulse_width: got %0d required 0", long_cnt); end
    endtask

    initial begin
        test_reset();
        test_unlock();
        test_overflow();
        test_lockout();
        test_timeout();
        test_held_and_reset();
        test_random();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 50000 cycles");
        $fatal(1);
    end
endmodule

// File: doc/pin_entry_ctrl.md
PIN_ENTRY_CTRL -- requirements
Module: pin_entry_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD digits in a complete entry (range 1-4).
REQ-002 Parameter TIMEOUT, default 28'd27000000: inactivity and lockout duration in clk cycles.
REQ-003 Parameter MAX_TRIES, default 3: consecutive failed submissions that trigger lockout.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 key  input  5  key code from the keypad scanner: 0-9 digits, 10-13 A-D, 14 #, 15 *, 31 none.
REQ-007 keypad_pressed  input  1  key-valid flag from the scanner, asynchronous to clk.
REQ-008 code_in  input  16  reference PIN, 4 BCD nibbles; only the low DIGITS nibbles are compared.
REQ-009 entry  output  16  digits entered so far, BCD; newest digit in [3:0].
REQ-010 digit_count  output  3  number of digits held in entry (0..DIGITS).
REQ-011 unlock  output  1  one-cycle pulse on a correct submission.
REQ-012 error  output  1  one-cycle pulse on a wrong or incomplete submission.
REQ-013 locked  output  1  high while in LOCKOUT.

Function
REQ-014 keypad_pressed SHALL pass through a 2-flop synchronizer; a key event SHALL be the rising edge of the synchronized signal, with key captured in the same cycle.
REQ-015 Latency: an event whose keypad_pressed rise is first sampled at edge N SHALL update entry/digit_count at edge N+3.
REQ-016 States: IDLE, ENTRY, CHECK, LOCKOUT; the state after reset is IDLE.
REQ-017 IDLE/ENTRY digit event with digit_count < DIGITS: entry <= {entry[11:0], key[3:0]}, digit_count +1, state -> ENTRY.
REQ-018 Digit event with digit_count == DIGITS: SHALL be ignored; entry and digit_count unchanged.
REQ-019 '*' event in IDLE/ENTRY: entry <= 0, digit_count <= 0, state -> IDLE.
REQ-020 '#' event in IDLE/ENTRY: state -> CHECK for exactly one cycle; entry frozen.
REQ-021 CHECK: digit_count == DIGITS and low DIGITS nibbles of entry equal code_in -> unlock pulse and tries <= 0; otherwise -> error pulse and tries +1.
REQ-022 CHECK exit: entry and digit_count cleared; state -> LOCKOUT if tries reaches MAX_TRIES, else -> IDLE.
REQ-023 A-D events and key == 31 SHALL be ignored in every state.
REQ-024 ENTRY: no event for TIMEOUT consecutive cycles -> entry and digit_count cleared, state -> IDLE, no error pulse; the counter SHALL restart on every event.
REQ-025 LOCKOUT: locked = 1, all events ignored; after TIMEOUT cycles -> IDLE, tries <= 0, locked = 0.
REQ-026 unlock and error SHALL never be high in the same cycle; each lasts exactly one cycle.
REQ-027 A key held down SHALL produce exactly one event; no repeats until keypad_pressed falls and rises again.

Reset
REQ-028 rst high SHALL immediately force state IDLE, entry 0, digit_count 0, unlock 0, error 0, locked 0, tries 0, timer 0, and clear the synchronizer flops.
REQ-029 rst asserted mid-entry or during LOCKOUT SHALL abort it; after release no event is generated until a new rising edge of keypad_pressed.

Configuration
REQ-030 Macro PIN_LOCKOUT_EN: when defined, tries counting and LOCKOUT operate as in REQ-021, REQ-022 and REQ-025.
REQ-031 Without PIN_LOCKOUT_EN: no tries counter and no LOCKOUT state; CHECK always returns to IDLE; locked is tied to 0.

Verification (DIGITS=4, code_in=16'h1234, TIMEOUT=100, MAX_TRIES=3 for simulation)
REQ-032 Keys 1,2,3,4,# -> entry 16'h1234 after the fourth digit; unlock pulses for 1 cycle; then entry=0 and digit_count=0.
REQ-033 Keys 1,2,3,4,5 -> fifth digit ignored, entry stays 16'h1234; then *, -> entry=0, digit_count=0, no pulse.
REQ-034 Keys 1,2,# -> error pulse (incomplete entry); three wrong submissions with PIN_LOCKOUT_EN -> locked=1 for 100 cycles, keys ignored, then IDLE.
REQ-035 Key 7 then 100 idle cycles -> entry cleared at cycle 100, no error pulse; 99 idle cycles then key 8 -> entry 16'h0078.
REQ-036 keypad_pressed held high for 50 cycles with key=5 -> exactly one digit stored; rst pulse mid-entry -> all outputs 0 within the reset cycle.
